ch_mod_engine: RTL and testbench
================================

Name: ch_mod_engine

Overview:
- Module-side client of a DMA channel FIFO bridge.
- Pops 64-bit words from the channel source FIFO via m_src_getn1 and applies the per-descriptor operation selected by dc1.
- Pushes results into the channel destination FIFO via m_dst_putn1, propagates the last-word flag, and signals end-of-stream on m_endn1 so the bridge flushes the remaining destination data to the ss side.

Parameters:
- DW, 64, data word width; matches the channel FIFO data width.
- PATTERN, 64'hA5A5_5A5A_A5A5_5A5A, XOR constant used by op 2'b11.

Ports:
- wb_clk_i  in  1  system clock; all logic on the rising edge.
- wb_rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse; begins a job; ignored unless IDLE.
- dc1  in  24  descriptor control. [1:0] op: 00 copy, 01 invert, 10 byte-swap, 11 XOR PATTERN. [23:2] reserved, ignored.
- m_reset1  out  1  one-cycle FIFO clear pulse issued at job start.
- m_src_getn1  out  1  active-low pop strobe for the source FIFO.
- m_src1  in  DW  source FIFO head word.
- m_src_last1  in  1  head word is the last of the stream.
- m_src_empty1  in  1  source FIFO empty.
- m_src_almost_empty1  in  1  source FIFO almost empty; status only.
- m_dst_putn1  out  1  active-low push strobe for the destination FIFO.
- m_dst1  out  DW  destination write data.
- m_dst_last1  out  1  last flag written alongside m_dst1.
- m_dst_full1  in  1  destination FIFO full.
- m_dst_almost_full1  in  1  destination FIFO almost full.
- m_endn1  out  1  active-low end-of-stream; low from the last push until the next start.
- busy_o  out  1  high while not IDLE.
- done_o  out  1  one-cycle pulse when a job completes.

Behaviour:
- Reset values: m_reset1=0, m_src_getn1=1, m_dst_putn1=1, m_dst1=0, m_dst_last1=0, m_endn1=1, busy_o=0, done_o=0, state=IDLE.
- dc1[1:0] is latched into op_q on start_i; dc1 changes mid-job have no effect.
- FSM states and transitions:
  - IDLE: start_i → CLR. Assert m_reset1 for exactly 1 cycle and drive m_endn1=1 on that same cycle.
  - CLR: → SETTLE unconditionally. This gives the FIFO flags one cycle to update after the clear.
  - SETTLE: if !m_src_empty1 → POP; else stay.
  - POP: m_src_getn1=0 for exactly 1 cycle.
    - Capture m_src1 and m_src_last1 into data_q/last_q this same cycle.
    - The capture is legal because the head word has been stable for ≥1 cycle, covering the RAM read latency.
    - → PUSH.
  - PUSH: if !m_dst_full1 and !m_dst_almost_full1:
    - Drive m_dst_putn1=0 for 1 cycle, with m_dst1=f(op_q,data_q) and m_dst_last1=last_q.
    - If last_q → END; else → SETTLE.
    - Otherwise hold in PUSH; putn stays 1 and data_q is held.
  - END: m_endn1←0, done_o=1 for 1 cycle → IDLE. m_endn1 stays 0 in IDLE until the next start.
- Pop cadence: at most 1 pop per 2 cycles; POP is never entered from POP. Sustained throughput is 1 word / 3 cycles.
- Operation f:
  - copy: data.
  - invert: ~data.
  - byte-swap: {d[7:0],d[15:8],…,d[63:56]}.
  - XOR: data^PATTERN.
- Output register: m_dst1 is registered and changes only on the PUSH cycle that pushes. Between pushes it holds the last pushed value.
- start_i outside IDLE is ignored; there is no queuing.
- Empty source mid-job: wait in SETTLE indefinitely; no timeout.
- Full destination: wait in PUSH. almost_full is also treated as blocking, which keeps 1 spare slot for the bridge's registered read path.
- Simultaneous events:
  - last_q with the destination full: the push waits, and END follows only after the push.
  - m_src_last1 on the first word: 1-word job, END after 1 push.
- Reset asserted mid-job: all outputs return to reset values immediately (asynchronous). No partial push occurs; putn goes to 1 combinationally via the reset flop.

Optional Feature:
- Macro CH_MOD_CSUM_EN.
- When defined, adds output csum_o [31:0]:
  - Cleared to 0 on start_i.
  - On each push: csum_o ← csum_o + m_dst1[63:32] + m_dst1[31:0], modulo 2^32.
  - Valid from the done_o cycle and held until the next start.
  - Reset value 0.
- When undefined: no port, no adder, behaviour otherwise identical.

Test Plan:
- Copy, 4 words 0x1…1, 0x2…2, 0x3…3, 0x4…4, last on word 4 → 4 putn pulses with identical data, m_dst_last1=1 only on 4th, m_endn1 low after, done_o one pulse.
- Byte-swap, 1 word 0x0011223344556677 with last → m_dst1=0x7766554433221100, m_dst_last1=1, exactly one getn and one putn.
- Invert with m_dst_full1 held high 10 cycles after first capture → no putn during stall, data held, push of ~data on the first cycle with full=0 and almost_full=0.
- Source empty gap of 7 cycles mid-stream, XOR op → getn never low while empty; outputs = data^PATTERN in order; start_i pulsed mid-job ignored.
- Reset pulled low during PUSH of word 2 of 5 → next cycle m_dst_putn1=1, m_src_getn1=1, m_endn1=1, busy_o=0; a new start after release runs a full job with m_reset1 pulsed once.
- CH_MOD_CSUM_EN defined, copy of 0x00000001_00000002 and 0xFFFFFFFF_00000001 → csum_o=0x00000003 at done_o.

Source files
------------

// File: rtl/ch_mod_engine.sv
// ch_mod_engine: channel FIFO client that pops source words, applies a per-job op, and pushes results.
// Optional CH_MOD_CSUM_EN adds a 32-bit running checksum of pushed words on csum_o.
module ch_mod_engine #(
    parameter int             DW      = 64,
    parameter logic [DW-1:0]  PATTERN = 64'hA5A5_5A5A_A5A5_5A5A
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          start_i,
    input  logic [23:0]   dc1,
    output logic          m_reset1,
    output logic          m_src_getn1,
    input  logic [DW-1:0] m_src1,
    input  logic          m_src_last1,
    input  logic          m_src_empty1,
    input  logic          m_src_almost_empty1,
    output logic          m_dst_putn1,
    output logic [DW-1:0] m_dst1,
    output logic          m_dst_last1,
    input  logic          m_dst_full1,
    input  logic          m_dst_almost_full1,
    output logic          m_endn1,
`ifdef CH_MOD_CSUM_EN
    output logic [31:0]   csum_o,
`endif
    output logic          busy_o,
    output logic          done_o
);

    // state  | meaning
    // IDLE   | waiting for start_i
    // CLR    | FIFO clear pulse on m_reset1
    // SETTLE | let FIFO flags update; wait for a source word
    // POP    | pop head word and capture it
    // PUSH   | push f(op,data) once the destination has room
    // ST_END | done pulse, back to IDLE
    typedef enum logic [2:0] {IDLE, CLR, SETTLE, POP, PUSH, ST_END} state_t;

    state_t        state, next_state;
    logic [1:0]    op_q;
    logic [DW-1:0] data_q;
    logic          last_q;
    logic          push_go;
    logic          putn_q;
    logic [DW-1:0] dst_q;
    logic          dst_last_q;
    logic          endn_q;
    logic [DW-1:0] f_val;

    logic unused_ok;
    assign unused_ok = ^{dc1[23:2], m_src_almost_empty1};

    function automatic logic [DW-1:0] bswap(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW/8; i++)
            r[8*i +: 8] = d[DW-8-8*i +: 8];
        return r;
    endfunction

    always_comb begin
        f_val = data_q;
        case (op_q)
            2'b00: f_val = data_q;
            2'b01: f_val = ~data_q;
            2'b10: f_val = bswap(data_q);
            2'b11: f_val = data_q ^ PATTERN;
            default: f_val = data_q;
        endcase
    end

    always_comb begin
        next_state = state;
        push_go    = 1'b0;
        case (state)
            IDLE:    if (start_i) next_state = CLR;
            CLR:     next_state = SETTLE;
            SETTLE:  if (!m_src_empty1) next_state = POP;
            POP:     next_state = PUSH;
            PUSH: begin
                // almost_full also blocks, leaving a spare slot for the bridge read path
                if (!m_dst_full1 && !m_dst_almost_full1) begin
                    push_go    = 1'b1;
                    next_state = last_q ? ST_END : SETTLE;
                end
            end
            ST_END:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state      <= IDLE;
            op_q       <= 2'b00;
            data_q     <= '0;
            last_q     <= 1'b0;
            putn_q     <= 1'b1;
            dst_q      <= '0;
            dst_last_q <= 1'b0;
            endn_q     <= 1'b1;
        end else begin
            state  <= next_state;
            putn_q <= !push_go;
            if (state == IDLE && start_i) begin
                op_q   <= dc1[1:0];
                endn_q <= 1'b1;
            end
            if (state == POP) begin
                data_q <= m_src1;
                last_q <= m_src_last1;
            end
            if (push_go) begin
                dst_q      <= f_val;
                dst_last_q <= last_q;
                if (last_q) endn_q <= 1'b0;
            end
        end
    end

`ifdef CH_MOD_CSUM_EN
    logic [31:0] csum_q;
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i)
            csum_q <= 32'h0;
        else if (state == IDLE && start_i)
            csum_q <= 32'h0;
        else if (push_go)
            csum_q <= csum_q + f_val[63:32] + f_val[31:0];
    end
    assign csum_o = csum_q;
`endif

    assign m_reset1    = (state == CLR);
    assign m_src_getn1 = (state != POP);
    assign m_dst_putn1 = putn_q;
    assign m_dst1      = dst_q;
    assign m_dst_last1 = dst_last_q;
    assign m_endn1     = endn_q;
    assign busy_o      = (state != IDLE);
    assign done_o      = (state == ST_END);

endmodule

// File: tb/tb_ch_mod_engine.sv
// Directed bench for ch_mod_engine with a behavioural source FIFO and destination capture.
// Define CH_MOD_CSUM_EN to also exercise csum_o.
module tb_ch_mod_engine;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        start_i;
    logic [23:0] dc1;
    logic        m_reset1;
    logic        m_src_getn1;
    logic [63:0] m_src1;
    logic        m_src_last1;
    logic        m_src_empty1;
    logic        m_src_almost_empty1;
    logic        m_dst_putn1;
    logic [63:0] m_dst1;
    logic        m_dst_last1;
    logic        m_dst_full1;
    logic        m_dst_almost_full1;
    logic        m_endn1;
    logic        busy_o;
    logic        done_o;
`ifdef CH_MOD_CSUM_EN
    logic [31:0] csum_o;
`endif

    ch_mod_engine dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i), .dc1(dc1),
        .m_reset1(m_reset1), .m_src_getn1(m_src_getn1), .m_src1(m_src1),
        .m_src_last1(m_src_last1), .m_src_empty1(m_src_empty1),
        .m_src_almost_empty1(m_src_almost_empty1), .m_dst_putn1(m_dst_putn1),
        .m_dst1(m_dst1), .m_dst_last1(m_dst_last1), .m_dst_full1(m_dst_full1),
        .m_dst_almost_full1(m_dst_almost_full1), .m_endn1(m_endn1),
`ifdef CH_MOD_CSUM_EN
        .csum_o(csum_o),
`endif
        .busy_o(busy_o), .done_o(done_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // source FIFO model: initial block appends, always block pops/flushes
    logic [63:0] mem   [0:255];
    logic        lastm [0:255];
    int          wr_cnt = 0;
    int          rd_ptr = 0;
    assign m_src_empty1        = (rd_ptr == wr_cnt);
    assign m_src_almost_empty1 = (wr_cnt - rd_ptr) <= 1;
    assign m_src1              = mem[rd_ptr[7:0]];
    assign m_src_last1         = lastm[rd_ptr[7:0]];

    logic [63:0] out_d [0:255];
    logic        out_l [0:255];
    int puts = 0, gets = 0, resets = 0, dones = 0, bad_pop = 0;

    always @(posedge wb_clk_i) begin
        if (m_reset1) rd_ptr <= wr_cnt;
        else if (!m_src_getn1 && !m_src_empty1) rd_ptr <= rd_ptr + 1;
        if (!m_src_getn1) begin
            gets <= gets + 1;
            if (m_src_empty1) bad_pop <= bad_pop + 1;
        end
        if (!m_dst_putn1) begin
            out_d[puts[7:0]] <= m_dst1;
            out_l[puts[7:0]] <= m_dst_last1;
            puts <= puts + 1;
        end
        if (m_reset1) resets <= resets + 1;
        if (done_o)   dones  <= dones + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [63:0] d, input logic l);
        mem[wr_cnt[7:0]]   = d;
        lastm[wr_cnt[7:0]] = l;
        wr_cnt++;
    endtask

    task automatic start_job(input logic [1:0] op);
        dc1     = {22'h2AAAAA, op};
        start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        chk("clr_pulse", {63'h0, m_reset1}, 64'h1);
        chk("clr_endn", {63'h0, m_endn1}, 64'h1);
        @(negedge wb_clk_i);
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (done_o) break;
            @(negedge wb_clk_i);
        end
        chk(tag, {63'h0, done_o}, 64'h1);
        @(negedge wb_clk_i);
    endtask

    int bp, bg, br, bd, stall_bad;
    logic [63:0] w;

    initial begin
        wb_rst_i = 1'b0; start_i = 1'b0; dc1 = 24'h0;
        m_dst_full1 = 1'b0; m_dst_almost_full1 = 1'b0;
        for (int i = 0; i < 256; i++) begin mem[i] = 64'h0; lastm[i] = 1'b0; end
        @(negedge wb_clk_i);
        chk("rst_getn", {63'h0, m_src_getn1}, 64'h1);
        chk("rst_putn", {63'h0, m_dst_putn1}, 64'h1);
        chk("rst_dst",  m_dst1, 64'h0);
        chk("rst_misc", {58'h0, m_reset1, m_dst_last1, m_endn1, busy_o, done_o, 1'b0}, 64'h08);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);

        // copy, 4 words
        bp = puts; bg = gets; bd = dones;
        start_job(2'b00);
        load(64'h1111_1111_1111_1111, 1'b0);
        load(64'h2222_2222_2222_2222, 1'b0);
        load(64'h3333_3333_3333_3333, 1'b0);
        load(64'h4444_4444_4444_4444, 1'b1);
        wait_done("copy_done", 60);
        chk("copy_nput", 64'(puts - bp), 64'd4);
        chk("copy_nget", 64'(gets - bg), 64'd4);
        for (int i = 0; i < 4; i++) begin
            w = {16{4'(i + 1)}};
            chk("copy_data", out_d[bp + i], w);
            chk("copy_last", {63'h0, out_l[bp + i]}, (i == 3) ? 64'h1 : 64'h0);
        end
        chk("copy_ndone", 64'(dones - bd), 64'd1);
        chk("copy_after", {61'h0, m_endn1, busy_o, done_o}, 64'h0);

        // byte swap, single word
        bp = puts; bg = gets;
        start_job(2'b10);
        load(64'h0011_2233_4455_6677, 1'b1);
        wait_done("bswap_done", 30);
        chk("bswap_nput", 64'(puts - bp), 64'd1);
        chk("bswap_nget", 64'(gets - bg), 64'd1);
        chk("bswap_data", out_d[bp], 64'h7766_5544_3322_1100);
        chk("bswap_last", {63'h0, out_l[bp]}, 64'h1);

        // invert with destination stall on the last word
        bp = puts; bg = gets;
        m_dst_full1 = 1'b1;
        start_job(2'b01);
        load(64'h0123_4567_89AB_CDEF, 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (gets - bg >= 1) break;
            @(negedge wb_clk_i);
        end
        chk("inv_popped", 64'(gets - bg), 64'd1);
        stall_bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (!m_dst_putn1 || done_o || m_dst1 !== 64'h7766_5544_3322_1100) stall_bad++;
            @(negedge wb_clk_i);
        end
        m_dst_full1 = 1'b0; m_dst_almost_full1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (!m_dst_putn1 || done_o) stall_bad++;
            @(negedge wb_clk_i);
        end
        chk("inv_stall", 64'(stall_bad), 64'd0);
        chk("inv_busy", {63'h0, busy_o}, 64'h1);
        m_dst_almost_full1 = 1'b0;
        @(negedge wb_clk_i);
        chk("inv_putn", {63'h0, m_dst_putn1}, 64'h0);
        chk("inv_data", m_dst1, 64'hFEDC_BA98_7654_3210);
        wait_done("inv_done", 10);
        chk("inv_nput", 64'(puts - bp), 64'd1);

        // XOR with empty gap, mid-job start and dc1 change ignored
        bp = puts; br = resets;
        start_job(2'b11);
        dc1 = 24'h0;
        load(64'h0000_0000_FFFF_FFFF, 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (puts - bp >= 1) break;
            @(negedge wb_clk_i);
        end
        bg = gets;
        for (int k = 0; k < 7; k++) begin
            start_i = (k == 3);
            @(negedge wb_clk_i);
        end
        start_i = 1'b0;
        chk("xor_gap_nget", 64'(gets - bg), 64'd0);
        load(64'h1234_5678_9ABC_DEF0, 1'b0);
        load(64'hA5A5_5A5A_A5A5_5A5A, 1'b1);
        wait_done("xor_done", 40);
        chk("xor_nput", 64'(puts - bp), 64'd3);
        chk("xor_d0", out_d[bp],     64'hA5A5_5A5A_5A5A_A5A5);
        chk("xor_d1", out_d[bp + 1], 64'hB791_0C22_3F19_84AA);
        chk("xor_d2", out_d[bp + 2], 64'h0);
        chk("xor_nrst", 64'(resets - br), 64'd1);
        chk("bad_pop", 64'(bad_pop), 64'd0);

        // reset during PUSH of word 2 of 5
        bp = puts; bg = gets;
        start_job(2'b00);
        for (int i = 0; i < 5; i++) load(64'hA0 + 64'(i), i == 4);
        for (int k = 0; k < 30; k++) begin
            if (gets - bg >= 2) break;
            @(negedge wb_clk_i);
        end
        chk("rmid_nget", 64'(gets - bg), 64'd2);
        wb_rst_i = 1'b0;
        #1;
        chk("rmid_async", {60'h0, m_dst_putn1, m_src_getn1, m_endn1, busy_o}, 64'hE);
        @(negedge wb_clk_i);
        chk("rmid_next", {60'h0, m_dst_putn1, m_src_getn1, m_endn1, busy_o}, 64'hE);
        chk("rmid_nput", 64'(puts - bp), 64'd1);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        bp = puts; br = resets;
        start_job(2'b00);
        load(64'hDEAD_BEEF_0000_0001, 1'b0);
        load(64'h0000_0000_CAFE_F00D, 1'b1);
        wait_done("rjob_done", 40);
        chk("rjob_nrst", 64'(resets - br), 64'd1);
        chk("rjob_nput", 64'(puts - bp), 64'd2);
        chk("rjob_d0", out_d[bp],     64'hDEAD_BEEF_0000_0001);
        chk("rjob_d1", out_d[bp + 1], 64'h0000_0000_CAFE_F00D);
        chk("rjob_endn", {63'h0, m_endn1}, 64'h0);

`ifdef CH_MOD_CSUM_EN
        start_job(2'b00);
        load(64'h0000_0001_0000_0002, 1'b0);
        load(64'hFFFF_FFFF_0000_0001, 1'b1);
        wait_done("csum_done", 40);
        chk("csum", {32'h0, csum_o}, 64'h3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
